// File: rtl/audio_gain_ramp_if.sv
// Sample/gain bus for audio_gain_ramp: parallel frame in, gain control, scaled frame out.
// The master drives samples and gain control; the slave (gain stage) returns the scaled frame.
interface audio_gain_ramp_if #(
    parameter int unsigned NCH = 2,
    parameter int unsigned DW  = 16,
    parameter int unsigned GW  = 16
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH*DW-1:0] in_data;
    logic              in_stb;
    logic              gain_wr;
    logic [CW-1:0]     gain_ch;
    logic [GW-1:0]     gain_val;
    logic              mute;
    logic [NCH*DW-1:0] out_data;
    logic              out_stb;
    logic              ramp_busy;
    logic              ovr;

    modport master (
        output in_data, in_stb, gain_wr, gain_ch, gain_val, mute,
        input  out_data, out_stb, ramp_busy, ovr
    );

    modport slave (
        input  in_data, in_stb, gain_wr, gain_ch, gain_val, mute,
        output out_data, out_stb, ramp_busy, ovr
    );
endinterface

// File: rtl/audio_gain_ramp.sv
// N-channel gain stage with one shared multiplier; each channel's applied gain slews toward
// its target by at most STEP per frame, and a global mute slews every channel to zero.
module audio_gain_ramp #(
    parameter int unsigned NCH  = 2,
    parameter int unsigned DW   = 16,
    parameter int unsigned GW   = 16,
    parameter int unsigned FRAC = 14,
    parameter int unsigned STEP = 64
) (
    input logic             clk,
    input logic             reset,
    audio_gain_ramp_if.slave bus
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PW = DW + GW + 1;

    localparam logic [GW-1:0] UNITY  = GW'(1 << FRAC);
    localparam logic [GW-1:0] STEP_G = (STEP >= (1 << GW)) ? '1 : GW'(STEP);
    localparam logic [CW-1:0] LAST   = CW'(NCH - 1);
    localparam logic [CW:0]   NCH_W  = (CW + 1)'(NCH);

    typedef enum logic [1:0] {StIdle, StMul, StFlush, StOut} state_e;

    state_e               state_q;
    logic [CW-1:0]        idx_q;
    logic [DW-1:0]        x_q     [NCH];
    logic [GW-1:0]        tgt_q   [NCH];
    logic [GW-1:0]        cur_q   [NCH];
    logic [DW-1:0]        stage_q [NCH];
    logic signed [PW-1:0] prod_q;
    logic                 prod_vld_q;
    logic [CW-1:0]        prod_ch_q;
    logic [NCH*DW-1:0]    out_data_q;
    logic                 out_stb_q;
    logic                 busy_q;
    logic                 ovr_q;

    logic [DW-1:0]        x_sel;
    logic [GW-1:0]        cur_sel;
    logic [GW-1:0]        eff_sel;
    logic [GW-1:0]        diff;
    logic [GW-1:0]        cur_step;
    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] prod_shr;
    logic [DW-1:0]        sat_val;
    logic                 busy_d;

    // Gain step for the channel currently in its multiply slot; uses the pre-write target.
    always_comb begin
        x_sel    = x_q[idx_q];
        cur_sel  = cur_q[idx_q];
        eff_sel  = bus.mute ? '0 : tgt_q[idx_q];
        diff     = '0;
        cur_step = cur_sel;
        if (cur_sel < eff_sel) begin
            diff     = eff_sel - cur_sel;
            cur_step = cur_sel + ((diff > STEP_G) ? STEP_G : diff);
        end else if (cur_sel > eff_sel) begin
            diff     = cur_sel - eff_sel;
            cur_step = cur_sel - ((diff > STEP_G) ? STEP_G : diff);
        end
    end

    // Gain is unsigned, so it enters the signed product zero-extended.
    always_comb begin
        prod_d = $signed({{(PW - DW){x_sel[DW-1]}}, x_sel}) *
                 $signed({{(PW - GW){1'b0}}, cur_sel});
    end

    always_comb begin
        prod_shr = prod_q >>> FRAC;
        if (prod_shr[PW-1:DW-1] == {(PW - DW + 1){prod_shr[PW-1]}}) begin
            sat_val = prod_shr[DW-1:0];
        end else if (prod_shr[PW-1]) begin
            sat_val = {1'b1, {(DW - 1){1'b0}}};
        end else begin
            sat_val = {1'b0, {(DW - 1){1'b1}}};
        end
    end

    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cur_q[i] != (bus.mute ? '0 : tgt_q[i])) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            prod_ch_q  <= '0;
            out_data_q <= '0;
            out_stb_q  <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                x_q[i]     <= '0;
                tgt_q[i]   <= UNITY;
                cur_q[i]   <= UNITY;
                stage_q[i] <= '0;
            end
        end else begin
            out_stb_q  <= 1'b0;
            prod_vld_q <= 1'b0;
            busy_q     <= busy_d;

            if (bus.gain_wr && ({1'b0, bus.gain_ch} < NCH_W)) begin
                tgt_q[bus.gain_ch] <= bus.gain_val;
            end
            if (bus.in_stb && (state_q != StIdle)) begin
                ovr_q <= 1'b1;
            end
            // Scale/saturate stage trails the multiply by one cycle.
            if (prod_vld_q) begin
                stage_q[prod_ch_q] <= sat_val;
            end

            case (state_q)
                StIdle: begin
                    if (bus.in_stb) begin
                        for (int i = 0; i < NCH; i++) begin
                            x_q[i] <= bus.in_data[i*DW +: DW];
                        end
                        idx_q   <= '0;
                        state_q <= StMul;
                    end
                end
                StMul: begin
                    prod_q       <= prod_d;
                    prod_vld_q   <= 1'b1;
                    prod_ch_q    <= idx_q;
                    cur_q[idx_q] <= cur_step;
                    if (idx_q == LAST) begin
                        state_q <= StFlush;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StFlush: begin
                    state_q <= StOut;
                end
                StOut: begin
                    for (int i = 0; i < NCH; i++) begin
                        out_data_q[i*DW +: DW] <= stage_q[i];
                    end
                    out_stb_q <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_stb   = out_stb_q;
    assign bus.ramp_busy = busy_q;
    assign bus.ovr       = ovr_q;
endmodule

// File: tb/tb_audio_gain_ramp.sv
// Scoreboard bench: stimulus queues expected frames, per-DUT monitors pop on out_stb.
// dut_a uses default parameters; dut_b uses STEP=0x4000 for the saturation case.
module tb_audio_gain_ramp;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    audio_gain_ramp_if #(.NCH(2), .DW(16), .GW(16)) a_if ();
    audio_gain_ramp_if #(.NCH(2), .DW(16), .GW(16)) b_if ();

    audio_gain_ramp #(.NCH(2), .DW(16), .GW(16), .FRAC(14), .STEP(64)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    audio_gain_ramp #(.NCH(2), .DW(16), .GW(16), .FRAC(14), .STEP(16384)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_if.out_stb) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_out_stb", 64'(a_if.out_data), 64'hdead_0000_0000);
            end else begin
                e = qa.pop_front();
                chk("a_out_data", 64'(a_if.out_data), 64'(e.data));
                chk("a_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_if.out_stb) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_out_stb", 64'(b_if.out_data), 64'hdead_0000_0000);
            end else begin
                e = qb.pop_front();
                chk("b_out_data", 64'(b_if.out_data), 64'(e.data));
                chk("b_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // One frame: strobe sampled at T0, returns at T4 + 1 time unit.
    task automatic frame(input bit sel_b, input logic [31:0] d, input logic [31:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        e.data = exp;
        e.cyc  = cyc + 5;
        if (sel_b) begin
            b_if.in_data = d;
            b_if.in_stb  = 1'b1;
            qb.push_back(e);
        end else begin
            a_if.in_data = d;
            a_if.in_stb  = 1'b1;
            qa.push_back(e);
        end
        @(posedge clk);
        #1;
        a_if.in_stb = 1'b0;
        b_if.in_stb = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic gain_write(input bit sel_b, input logic ch, input logic [15:0] val);
        @(posedge clk);
        #1;
        if (sel_b) begin
            b_if.gain_wr = 1'b1; b_if.gain_ch = ch; b_if.gain_val = val;
        end else begin
            a_if.gain_wr = 1'b1; a_if.gain_ch = ch; a_if.gain_val = val;
        end
        @(posedge clk);
        #1;
        a_if.gain_wr = 1'b0;
        b_if.gain_wr = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] ramp_r [5];
        exp_t e;
        ramp_r = '{16'h4000, 16'h3FC0, 16'h3F80, 16'h3F40, 16'h3F00};

        a_if.in_data = '0; a_if.in_stb = 1'b0; a_if.gain_wr = 1'b0;
        a_if.gain_ch = '0; a_if.gain_val = '0; a_if.mute = 1'b0;
        b_if.in_data = '0; b_if.in_stb = 1'b0; b_if.gain_wr = 1'b0;
        b_if.gain_ch = '0; b_if.gain_val = '0; b_if.mute = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;

        chk("reset_out_data", 64'(a_if.out_data), 64'h0);
        chk("reset_out_stb", 64'(a_if.out_stb), 64'h0);
        chk("reset_busy", 64'(a_if.ramp_busy), 64'h0);
        chk("reset_ovr", 64'(a_if.ovr), 64'h0);

        // Unity pass-through, including a negative sample.
        frame(1'b0, {16'hEDCC, 16'h1234}, {16'hEDCC, 16'h1234});
        chk("unity_busy", 64'(a_if.ramp_busy), 64'h0);

        // Saturation at gain 2.0.
        gain_write(1'b1, 1'b0, 16'h8000);
        gain_write(1'b1, 1'b1, 16'h8000);
        frame(1'b1, 32'h0, 32'h0);
        frame(1'b1, {16'hB000, 16'h5000}, {16'h8000, 16'h7FFF});
        frame(1'b1, {16'hF000, 16'h1000}, {16'hE000, 16'h2000});
        chk("sat_busy", 64'(b_if.ramp_busy), 64'h0);

        // Ramp ch1 toward 0x3F00 by 0x40 per frame; ch0 untouched.
        gain_write(1'b0, 1'b1, 16'h3F00);
        for (int k = 0; k < 5; k++) begin
            frame(1'b0, {16'h4000, 16'h1000}, {ramp_r[k], 16'h1000});
            chk("ramp_busy", 64'(a_if.ramp_busy), (k < 3) ? 64'h1 : 64'h0);
        end

        // Reset two cycles into a frame: frame abandoned, gains back to unity.
        @(posedge clk);
        #1;
        a_if.in_data = {16'h1111, 16'h2222};
        a_if.in_stb  = 1'b1;
        @(posedge clk);
        #1;
        a_if.in_stb = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_out_data", 64'(a_if.out_data), 64'h0);
        chk("midrst_ovr", 64'(a_if.ovr), 64'h0);
        chk("midrst_busy", 64'(a_if.ramp_busy), 64'h0);
        frame(1'b0, {16'h3000, 16'h4000}, {16'h3000, 16'h4000});

        // Overrun: second strobe two cycles after the first is dropped.
        @(posedge clk);
        #1;
        a_if.in_data = {16'h0ABC, 16'h0123};
        a_if.in_stb  = 1'b1;
        e.data = {16'h0ABC, 16'h0123};
        e.cyc  = cyc + 5;
        qa.push_back(e);
        @(posedge clk);
        #1;
        a_if.in_stb = 1'b0;
        @(posedge clk);
        #1;
        a_if.in_data = {16'h7777, 16'h6666};
        a_if.in_stb  = 1'b1;
        @(posedge clk);
        #1;
        a_if.in_stb = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_set", 64'(a_if.ovr), 64'h1);
        frame(1'b0, {16'h0001, 16'hFFFF}, {16'h0001, 16'hFFFF});
        chk("ovr_sticky", 64'(a_if.ovr), 64'h1);
        do_reset();
        chk("ovr_cleared", 64'(a_if.ovr), 64'h0);

        // Soft mute down to zero over 257 frames, then back up; target retained.
        a_if.mute = 1'b1;
        for (int k = 0; k < 257; k++) begin
            frame(1'b0, {16'h0000, 16'h4000}, {16'h0000, 16'(32'h4000 - 32'h40 * k)});
            if (k == 0) chk("mute_busy_start", 64'(a_if.ramp_busy), 64'h1);
        end
        chk("mute_busy_end", 64'(a_if.ramp_busy), 64'h0);
        a_if.mute = 1'b0;
        for (int k = 0; k < 257; k++) begin
            frame(1'b0, {16'h0000, 16'h4000}, {16'h0000, 16'(32'h40 * k)});
            if (k == 0) chk("unmute_busy_start", 64'(a_if.ramp_busy), 64'h1);
        end
        chk("unmute_busy_end", 64'(a_if.ramp_busy), 64'h0);

        for (int i = 0; i < 50 && (qa.size() + qb.size()) != 0; i++) @(posedge clk);
        chk("queues_drained", 64'(qa.size() + qb.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
